// File: rtl/cnn_pkg.sv
// Shared CNN core constants and the conv engine control-state encoding.
package cnn_pkg;

    localparam int DATA_W      = 8;
    localparam int ACC_W       = 21;
    localparam int KERNEL_TAPS = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CAPTURE,
        ST_RUN,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/conv3x3_engine_mac_row3.sv
// One kernel row: three pixel x weight products (stage 1) and their signed row sum (stage 2).
module mac_row3 #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int ACC_W  = cnn_pkg::ACC_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  adv_i,
    input  logic                  valid_i,
    input  logic [3*DATA_W-1:0]   pix_i,
    input  logic [3*DATA_W-1:0]   wgt_i,
    output logic                  s1_valid_o,
    output logic                  s2_valid_o,
    output logic [ACC_W-1:0]      sum_o
);

    localparam int PROD_W = 2*DATA_W + 1;

    logic [2:0][PROD_W-1:0] prod_d, prod_q;
    logic [ACC_W-1:0]       sum_d, sum_q;
    logic                   s1_valid_q, s2_valid_q;

    // Operands are extended to the product width up front so the multiply is
    // exact modulo 2^PROD_W: pixel zero-extended, weight sign-extended.
    always_comb begin
        prod_d = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            prod_d[i] = {{(PROD_W-DATA_W){1'b0}}, pix_i[i*DATA_W +: DATA_W]} *
                        {{(PROD_W-DATA_W){wgt_i[i*DATA_W+DATA_W-1]}}, wgt_i[i*DATA_W +: DATA_W]};
        end
    end

    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            sum_d = sum_d + {{(ACC_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            prod_q     <= '0;
            sum_q      <= '0;
        end else if (adv_i) begin
            s1_valid_q <= valid_i;
            prod_q     <= prod_d;
            s2_valid_q <= s1_valid_q;
            sum_q      <= sum_d;
        end
    end

    assign s1_valid_o = s1_valid_q;
    assign s2_valid_o = s2_valid_q;
    assign sum_o      = sum_q;

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine: kernel load FSM, weight registers, final adder/ReLU stage and handshake.
module conv3x3_engine #(
    parameter int DATA_W  = cnn_pkg::DATA_W,
    parameter int ACC_W   = cnn_pkg::ACC_W,
    parameter int RELU_EN = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  kernel_full_i,
    output logic                  kernel_read_o,
    input  logic [DATA_W-1:0]     k0_i,
    input  logic [DATA_W-1:0]     k1_i,
    input  logic [DATA_W-1:0]     k2_i,
    input  logic [DATA_W-1:0]     k3_i,
    input  logic [DATA_W-1:0]     k4_i,
    input  logic [DATA_W-1:0]     k5_i,
    input  logic [DATA_W-1:0]     k6_i,
    input  logic [DATA_W-1:0]     k7_i,
    input  logic [DATA_W-1:0]     k8_i,
    input  logic                  reload_i,
    output logic                  weights_loaded_o,
    input  logic                  win_valid_i,
    output logic                  win_ready_o,
    input  logic [9*DATA_W-1:0]   win_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ACC_W-1:0]      out_data_o
);

    import cnn_pkg::*;

    state_t                                state_q;
    logic                                  kernel_read_q, loaded_q;
    logic [KERNEL_TAPS-1:0][DATA_W-1:0]    w_q, k_all;
    logic                                  adv, accept, pipe_empty;
    logic [2:0]                            s1_valid, s2_valid;
    logic [2:0][ACC_W-1:0]                 row_sum;
    logic [ACC_W-1:0]                      total, out_data_d, out_data_q;
    logic                                  out_valid_q;

    assign k_all       = {k8_i, k7_i, k6_i, k5_i, k4_i, k3_i, k2_i, k1_i, k0_i};
    assign adv         = ~out_valid_q | out_ready_i;
    // loaded_q is high exactly while in RUN
    assign win_ready_o = loaded_q & adv;
    assign accept      = win_valid_i & win_ready_o;
    assign pipe_empty  = ~(|s1_valid) & ~(|s2_valid) & ~out_valid_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            kernel_read_q <= 1'b0;
            loaded_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (kernel_full_i) begin
                    state_q       <= ST_LOAD;
                    kernel_read_q <= 1'b1;
                end
                ST_LOAD: begin
                    state_q       <= ST_CAPTURE;
                    kernel_read_q <= 1'b0;
                end
                ST_CAPTURE: begin
                    state_q  <= ST_RUN;
                    loaded_q <= 1'b1;
                end
                ST_RUN: if (reload_i) begin
                    state_q  <= ST_DRAIN;
                    loaded_q <= 1'b0;
                end
                ST_DRAIN: if (pipe_empty) state_q <= ST_IDLE;
                default: begin
                    state_q       <= ST_IDLE;
                    kernel_read_q <= 1'b0;
                    loaded_q      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)                    w_q <= '0;
        else if (state_q == ST_CAPTURE) w_q <= k_all;
    end

    for (genvar r = 0; r < 3; r++) begin : g_row
        mac_row3 #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_row (
            .clk        (clk),
            .resetn     (resetn),
            .adv_i      (adv),
            .valid_i    (accept),
            .pix_i      (win_data_i[r*3*DATA_W +: 3*DATA_W]),
            .wgt_i      (w_q[r*3 +: 3]),
            .s1_valid_o (s1_valid[r]),
            .s2_valid_o (s2_valid[r]),
            .sum_o      (row_sum[r])
        );
    end

    always_comb begin
        total      = row_sum[0] + row_sum[1] + row_sum[2];
        out_data_d = total;
        if ((RELU_EN != 0) && total[ACC_W-1]) out_data_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (adv) begin
            out_valid_q <= |s2_valid;
            if (|s2_valid) out_data_q <= out_data_d;
        end
    end

    assign kernel_read_o    = kernel_read_q;
    assign weights_loaded_o = loaded_q;
    assign out_valid_o      = out_valid_q;
    assign out_data_o       = out_data_q;

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine: one ReLU and one non-ReLU instance share all inputs.
module tb_conv3x3_engine;

    import cnn_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, kernel_full, reload, win_valid, out_ready;
    logic [7:0]  kin [9];
    logic [71:0] win_data;
    logic        kread, loaded, wready, ovalid;
    logic [20:0] odata;
    logic        kread_n, loaded_n, wready_n, ovalid_n;
    logic [20:0] odata_n;

    int checks = 0;
    int errors = 0;

    logic [7:0] w_ones [9];
    logic [7:0] w_m1   [9];
    logic [7:0] w_mix  [9];
    logic [7:0] w_two  [9];
    logic [7:0] cur_w  [9];
    int q_r [$];
    int q_n [$];

    always #5 clk = ~clk;

    conv3x3_engine #(.DATA_W(8), .ACC_W(21), .RELU_EN(1)) dut (
        .clk(clk), .resetn(resetn), .kernel_full_i(kernel_full), .kernel_read_o(kread),
        .k0_i(kin[0]), .k1_i(kin[1]), .k2_i(kin[2]), .k3_i(kin[3]), .k4_i(kin[4]),
        .k5_i(kin[5]), .k6_i(kin[6]), .k7_i(kin[7]), .k8_i(kin[8]),
        .reload_i(reload), .weights_loaded_o(loaded), .win_valid_i(win_valid),
        .win_ready_o(wready), .win_data_i(win_data), .out_valid_o(ovalid),
        .out_ready_i(out_ready), .out_data_o(odata)
    );

    conv3x3_engine #(.DATA_W(8), .ACC_W(21), .RELU_EN(0)) dut_nr (
        .clk(clk), .resetn(resetn), .kernel_full_i(kernel_full), .kernel_read_o(kread_n),
        .k0_i(kin[0]), .k1_i(kin[1]), .k2_i(kin[2]), .k3_i(kin[3]), .k4_i(kin[4]),
        .k5_i(kin[5]), .k6_i(kin[6]), .k7_i(kin[7]), .k8_i(kin[8]),
        .reload_i(reload), .weights_loaded_o(loaded_n), .win_valid_i(win_valid),
        .win_ready_o(wready_n), .win_data_i(win_data), .out_valid_o(ovalid_n),
        .out_ready_i(out_ready), .out_data_o(odata_n)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] pat(input int n);
        logic [71:0] v;
        for (int i = 0; i < 9; i++) v[i*8 +: 8] = 8'((n*37 + i*29 + 5) & 255);
        return v;
    endfunction

    function automatic int model(input logic [71:0] win, input logic [7:0] w [9], input bit relu);
        int s = 0;
        for (int i = 0; i < 9; i++) s += int'(win[i*8 +: 8]) * int'($signed(w[i]));
        if (relu && s < 0) s = 0;
        return s;
    endfunction

    task automatic load_w(input logic [7:0] w [9]);
        int n = 0;
        for (int i = 0; i < 9; i++) begin
            kin[i]   = w[i];
            cur_w[i] = w[i];
        end
        kernel_full = 1'b1;
        while (!loaded && n < 10) begin
            tick();
            n++;
        end
        kernel_full = 1'b0;
        chk("load_done", int'(loaded), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (dut.state_q != ST_IDLE && n < 20) begin
            tick();
            n++;
        end
        chk(tag, int'(dut.state_q == ST_IDLE), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, cyc, stale, e;

        w_ones = '{default: 8'd1};
        w_m1   = '{default: 8'hFF};
        w_two  = '{default: 8'd2};
        w_mix  = '{8'd1, 8'hFE, 8'd3, 8'hFC, 8'd5, 8'hFA, 8'd7, 8'hF8, 8'd9};
        kin    = '{default: 8'd0};

        resetn = 1'b0; kernel_full = 1'b0; reload = 1'b0;
        win_valid = 1'b0; out_ready = 1'b0; win_data = '0;
        tick(); tick();
        chk("rst_kread",  int'(kread),  0);
        chk("rst_loaded", int'(loaded), 0);
        chk("rst_wready", int'(wready), 0);
        chk("rst_ovalid", int'(ovalid), 0);
        chk("rst_odata",  int'(odata),  0);
        resetn = 1'b1; out_ready = 1'b1;
        tick();

        // Load sequence, cycle by cycle
        kin = w_ones; cur_w = w_ones; kernel_full = 1'b1;
        tick();
        chk("load_kread_on",  int'(kread),  1);
        chk("load_loaded_c1", int'(loaded), 0);
        kernel_full = 1'b0;
        tick();
        chk("load_kread_off", int'(kread),  0);
        chk("load_loaded_c2", int'(loaded), 0);
        tick();
        chk("load_loaded_c3", int'(loaded), 1);
        chk("load_kread_c3",  int'(kread),  0);
        kin = '{default: 8'h55};

        // Basic window, latency and back-pressure hold
        win_data = {9{8'd10}}; win_valid = 1'b1;
        chk("basic_ready", int'(wready), 1);
        tick();
        win_valid = 1'b0;
        chk("basic_lat1", int'(ovalid), 0);
        tick();
        chk("basic_lat2", int'(ovalid), 0);
        tick();
        chk("basic_valid", int'(ovalid), 1);
        chk("basic_data",  int'($signed(odata)), 90);
        out_ready = 1'b0;
        #1;
        chk("bp_ready_drop", int'(wready), 0);
        tick();
        chk("bp_hold_valid", int'(ovalid), 1);
        chk("bp_hold_data",  int'($signed(odata)), 90);
        out_ready = 1'b1;
        tick();
        chk("bp_released", int'(ovalid), 0);

        // Signed weights, ReLU on and off
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("reload_loaded_low", int'(loaded), 0);
        wait_idle("reload1_idle");
        load_w(w_m1);
        win_data = {9{8'hFF}}; win_valid = 1'b1;
        tick();
        win_valid = 1'b0;
        tick(); tick();
        chk("signed_valid",   int'(ovalid), 1);
        chk("signed_relu",    int'($signed(odata)), 0);
        chk("signed_norelu",  int'($signed(odata_n)), -2295);

        // 20-window stream with random output back-pressure
        reload = 1'b1;
        tick();
        reload = 1'b0;
        wait_idle("reload2_idle");
        load_w(w_mix);
        sent = 0; got = 0; cyc = 0;
        while (got < 20 && cyc < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            win_valid = (sent < 20);
            win_data  = pat(sent);
            @(negedge clk);
            if (ovalid && out_ready) begin
                if (q_r.size() > 0) begin
                    chk("stream_relu",   int'($signed(odata)),   q_r.pop_front());
                    chk("stream_norelu", int'($signed(odata_n)), q_n.pop_front());
                end else begin
                    chk("stream_extra_output", 1, 0);
                end
                got++;
            end
            if (win_valid && wready) begin
                q_r.push_back(model(pat(sent), cur_w, 1'b1));
                q_n.push_back(model(pat(sent), cur_w, 1'b0));
                sent++;
            end
            tick();
            cyc++;
        end
        win_valid = 1'b0; out_ready = 1'b1;
        chk("stream_sent", sent, 20);
        chk("stream_got",  got,  20);
        tick(); tick(); tick();
        chk("stream_no_dup", int'(ovalid), 0);

        // Reload with two windows in flight; the second is accepted with reload
        win_valid = 1'b1; win_data = pat(100);
        tick();
        q_r.push_back(model(pat(100), cur_w, 1'b1));
        win_data = pat(101); reload = 1'b1;
        chk("reload_same_cycle_ready", int'(wready), 1);
        tick();
        q_r.push_back(model(pat(101), cur_w, 1'b1));
        reload = 1'b0; win_valid = 1'b0;
        kin = w_two;
        chk("drain_ready_low", int'(wready), 0);
        got = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ovalid) begin
                e = (q_r.size() > 0) ? q_r.pop_front() : -1;
                chk("drain_old_weights", int'($signed(odata)), e);
                got++;
            end
            tick();
        end
        chk("drain_count", got, 2);
        wait_idle("drain_idle");
        chk("drain_loaded", int'(loaded), 0);
        load_w(w_two);
        win_data = {9{8'd1}}; win_valid = 1'b1;
        tick();
        win_valid = 1'b0;
        tick(); tick();
        chk("newload_valid", int'(ovalid), 1);
        chk("newload_data",  int'($signed(odata)), 18);
        tick();

        // Reset with three windows in flight
        win_valid = 1'b1;
        win_data = pat(200); tick();
        win_data = pat(201); tick();
        win_data = pat(202); tick();
        win_valid = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("mrst_ovalid", int'(ovalid), 0);
        chk("mrst_state",  int'(dut.state_q == ST_IDLE), 1);
        chk("mrst_loaded", int'(loaded), 0);
        chk("mrst_odata",  int'(odata),  0);
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ovalid || ovalid_n) stale++;
            tick();
        end
        chk("mrst_no_stale", stale, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
